// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signals seen by the hazard/stall controller.
// The master side is the pipeline datapath; the slave side is the controller.
interface hazard_stall_ctrl_if #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned PERF_W     = 16
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rt;
   logic                  id_is_branch;
   logic                  branch_taken;
   logic                  jump;
   logic [REG_ADDR_W-1:0] ex_dest;
   logic                  ex_wb_en;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] mem_dest;
   logic                  mem_wb_en;
   logic                  mem_mem_read;
   logic                  mem_busy;
   logic                  perf_clr;
   logic                  pc_write;
   logic                  ifid_write;
   logic                  hazard_detected;
   logic                  ifid_flush;
   logic                  pipe_freeze;
   logic [1:0]            state;
   logic [PERF_W-1:0]     stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rt, id_is_branch, branch_taken, jump,
             ex_dest, ex_wb_en, ex_mem_read, mem_dest, mem_wb_en, mem_mem_read,
             mem_busy, perf_clr,
      input  pc_write, ifid_write, hazard_detected, ifid_flush, pipe_freeze,
             state, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rt, id_is_branch, branch_taken, jump,
             ex_dest, ex_wb_en, ex_mem_read, mem_dest, mem_wb_en, mem_mem_read,
             mem_busy, perf_clr,
      output pc_write, ifid_write, hazard_detected, ifid_flush, pipe_freeze,
             state, stall_count
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Data-hazard stall controller for a 5-stage pipeline with branches resolved in ID.
// Pipeline controls are combinational; state and the stall counter are registered.
module hazard_stall_ctrl #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned PERF_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   hazard_stall_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = 2;
   localparam int unsigned N_W   = 2;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [PERF_W-1:0] perf_q;

   logic           ex_match;
   logic           mem_match;
   logic [N_W-1:0] need;

   logic pc_write;
   logic ifid_write;
   logic hazard_detected;
   logic ifid_flush;
   logic pipe_freeze;

   // Producer matches; register 0 is hardwired and never a dependency
   always_comb begin
      ex_match  = bus.ex_wb_en && (bus.ex_dest != REG_ADDR_W'(0)) &&
                  ((bus.ex_dest == bus.id_rs) || (bus.id_uses_rt && (bus.ex_dest == bus.id_rt)));
      mem_match = bus.mem_wb_en && (bus.mem_dest != REG_ADDR_W'(0)) &&
                  ((bus.mem_dest == bus.id_rs) || (bus.id_uses_rt && (bus.mem_dest == bus.id_rt)));
   end

   // Bubble count still owed by the ID instruction
   always_comb begin
      need = N_W'(0);
      if (bus.id_valid) begin
         if (bus.id_is_branch) begin
            if (ex_match && bus.ex_mem_read)         need = N_W'(2);
            else if (ex_match)                        need = N_W'(1);
            else if (mem_match && bus.mem_mem_read)   need = N_W'(1);
         end else if (ex_match && bus.ex_mem_read) begin
            need = N_W'(1);
         end
      end
   end

   // Next state and pipeline controls
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      pc_write        = 1'b0;
      ifid_write      = 1'b0;
      hazard_detected = 1'b0;
      ifid_flush      = 1'b0;
      pipe_freeze     = 1'b0;
      if (!rst) begin
         hazard_detected = 1'b1;
         state_d         = RUN;
         cnt_d           = CNT_W'(0);
      end else if (bus.mem_busy) begin
         pipe_freeze = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (need == N_W'(0)) begin
                  pc_write   = 1'b1;
                  ifid_write = 1'b1;
                  ifid_flush = bus.id_valid && (bus.branch_taken || bus.jump);
               end else begin
                  hazard_detected = 1'b1;
                  if (need == N_W'(2)) begin
                     state_d = STALL;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            STALL: begin
               hazard_detected = 1'b1;
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = RUN;
                  cnt_d   = CNT_W'(0);
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = CNT_W'(0);
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= CNT_W'(0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Saturating bubble counter; clear has priority
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_q <= PERF_W'(0);
      end else if (bus.perf_clr) begin
         perf_q <= PERF_W'(0);
      end else if (hazard_detected && (perf_q != {PERF_W{1'b1}})) begin
         perf_q <= perf_q + PERF_W'(1);
      end
   end

   assign bus.pc_write        = pc_write;
   assign bus.ifid_write      = ifid_write;
   assign bus.hazard_detected = hazard_detected;
   assign bus.ifid_flush      = ifid_flush;
   assign bus.pipe_freeze     = pipe_freeze;
   assign bus.state           = 2'(state_q);
   assign bus.stall_count     = perf_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a bubbles-remaining reference model.
module tb_hazard_stall_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   bit   cmp_en;

   int          m_rem;
   logic [15:0] m_count;

   hazard_stall_ctrl_if #(.REG_ADDR_W(5), .PERF_W(16)) bus ();

   hazard_stall_ctrl #(.REG_ADDR_W(5), .PERF_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bubbles demanded by the ID instruction, straight from the rule table
   function automatic int need();
      bit ex_m;
      bit mem_m;
      ex_m  = bus.ex_wb_en && bus.ex_dest != 0 &&
              (bus.ex_dest == bus.id_rs || (bus.id_uses_rt && bus.ex_dest == bus.id_rt));
      mem_m = bus.mem_wb_en && bus.mem_dest != 0 &&
              (bus.mem_dest == bus.id_rs || (bus.id_uses_rt && bus.mem_dest == bus.id_rt));
      if (!bus.id_valid) return 0;
      if (bus.id_is_branch && ex_m && bus.ex_mem_read) return 2;
      if (bus.id_is_branch && ex_m) return 1;
      if (bus.id_is_branch && mem_m && bus.mem_mem_read) return 1;
      if (!bus.id_is_branch && ex_m && bus.ex_mem_read) return 1;
      return 0;
   endfunction

   // Expected {pc_write, ifid_write, hazard_detected, ifid_flush, pipe_freeze}
   function automatic logic [4:0] exp_ctrl();
      if (!rst) return 5'b00100;
      if (bus.mem_busy) return 5'b00001;
      if (m_rem > 0) return 5'b00100;
      if (need() == 0) return {2'b11, 1'b0, bus.id_valid && (bus.branch_taken || bus.jump), 1'b0};
      return 5'b00100;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_rem   <= 0;
         m_count <= 16'h0;
      end else begin
         if (bus.perf_clr) m_count <= 16'h0;
         else if ((exp_ctrl() & 5'b00100) != 5'b0 && m_count != 16'hFFFF) m_count <= m_count + 16'h1;
         if (!bus.mem_busy) begin
            if (m_rem > 0) m_rem <= m_rem - 1;
            else if (need() > 0) m_rem <= need() - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ctrl", 32'({bus.pc_write, bus.ifid_write, bus.hazard_detected,
                           bus.ifid_flush, bus.pipe_freeze}), 32'(exp_ctrl()));
         check("state", 32'(bus.state), (m_rem > 0) ? 32'd1 : 32'd0);
         check("stall_count", 32'(bus.stall_count), 32'(m_count));
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.id_valid     = 1'b0;
      bus.id_rs        = 5'd0;
      bus.id_rt        = 5'd0;
      bus.id_uses_rt   = 1'b0;
      bus.id_is_branch = 1'b0;
      bus.branch_taken = 1'b0;
      bus.jump         = 1'b0;
      bus.ex_dest      = 5'd0;
      bus.ex_wb_en     = 1'b0;
      bus.ex_mem_read  = 1'b0;
      bus.mem_dest     = 5'd0;
      bus.mem_wb_en    = 1'b0;
      bus.mem_mem_read = 1'b0;
      bus.mem_busy     = 1'b0;
      bus.perf_clr     = 1'b0;
   endtask

   task automatic set_branch_after_load();
      set_idle();
      bus.id_valid     = 1'b1;
      bus.id_is_branch = 1'b1;
      bus.id_rs        = 5'd3;
      bus.id_rt        = 5'd7;
      bus.id_uses_rt   = 1'b1;
      bus.ex_dest      = 5'd7;
      bus.ex_wb_en     = 1'b1;
      bus.ex_mem_read  = 1'b1;
   endtask

   initial begin
      bit found;
      checks = 0;
      errors = 0;
      cmp_en = 1'b0;
      rst    = 1'b0;
      set_idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_count", 32'(bus.stall_count), 32'd0);
      check("rst_ctrl", 32'({bus.pc_write, bus.ifid_write, bus.hazard_detected,
                             bus.ifid_flush, bus.pipe_freeze}), 32'b00100);
      rst    = 1'b1;
      cmp_en = 1'b1;

      // Load-use: one bubble
      next();
      set_idle();
      bus.id_valid = 1'b1; bus.id_rs = 5'd5;
      bus.ex_dest = 5'd5; bus.ex_wb_en = 1'b1; bus.ex_mem_read = 1'b1;
      at_neg();
      check("lu_hz", 32'(bus.hazard_detected), 32'd1);
      check("lu_pc", 32'(bus.pc_write), 32'd0);
      next();
      bus.ex_wb_en = 1'b0; bus.ex_mem_read = 1'b0;
      at_neg();
      check("lu_pc_after", 32'(bus.pc_write), 32'd1);
      check("lu_count", 32'(bus.stall_count), 32'd1);

      // Branch after load: two bubbles
      next();
      set_idle();
      bus.perf_clr = 1'b1;
      next();
      set_branch_after_load();
      at_neg();
      check("bl_hz1", 32'(bus.hazard_detected), 32'd1);
      check("bl_state1", 32'(bus.state), 32'd0);
      next();
      at_neg();
      check("bl_hz2", 32'(bus.hazard_detected), 32'd1);
      check("bl_state2", 32'(bus.state), 32'd1);
      next();
      set_idle();
      at_neg();
      check("bl_hz_done", 32'(bus.hazard_detected), 32'd0);
      check("bl_count", 32'(bus.stall_count), 32'd2);

      // Zero register never stalls
      bus.id_valid = 1'b1; bus.ex_wb_en = 1'b1; bus.ex_mem_read = 1'b1;
      at_neg();
      check("zr_hz", 32'(bus.hazard_detected), 32'd0);
      check("zr_pc", 32'(bus.pc_write), 32'd1);

      // Taken branch flush, suppressed while stalling
      next();
      set_idle();
      bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.branch_taken = 1'b1;
      bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_uses_rt = 1'b1;
      at_neg();
      check("tb_flush", 32'(bus.ifid_flush), 32'd1);
      check("tb_pc", 32'(bus.pc_write), 32'd1);
      next();
      bus.ex_wb_en = 1'b1; bus.ex_dest = 5'd1;
      at_neg();
      check("tb_flush_stall", 32'(bus.ifid_flush), 32'd0);
      check("tb_hz_stall", 32'(bus.hazard_detected), 32'd1);
      next();
      bus.ex_wb_en = 1'b0;
      at_neg();
      check("tb_flush_after", 32'(bus.ifid_flush), 32'd1);

      // mem_busy freezes STALL
      next();
      set_branch_after_load();
      next();
      bus.mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         check("mb_freeze", 32'(bus.pipe_freeze), 32'd1);
         check("mb_hz", 32'(bus.hazard_detected), 32'd0);
         check("mb_state", 32'(bus.state), 32'd1);
         next();
      end
      bus.mem_busy = 1'b0;
      at_neg();
      check("mb_bubble", 32'(bus.hazard_detected), 32'd1);
      check("mb_bubble_state", 32'(bus.state), 32'd1);
      next();
      set_idle();
      at_neg();
      check("mb_run", 32'(bus.state), 32'd0);

      // Saturation, then async reset in STALL, then clear-vs-increment
      next();
      set_branch_after_load();
      repeat (65540) next();
      at_neg();
      check("sat_count", 32'(bus.stall_count), 32'hFFFF);
      found = (bus.state == 2'b01);
      for (int i = 0; i < 4 && !found; i++) begin
         next();
         at_neg();
         found = (bus.state == 2'b01);
      end
      check("sat_in_stall", 32'(found), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("ar_state", 32'(bus.state), 32'd0);
      check("ar_count", 32'(bus.stall_count), 32'd0);
      next();
      rst = 1'b1;
      bus.perf_clr = 1'b1;
      at_neg();
      check("ar_run_first", 32'(bus.state), 32'd0);
      check("ar_hz_first", 32'(bus.hazard_detected), 32'd1);
      next();
      at_neg();
      check("clr_wins", 32'(bus.stall_count), 32'd0);
      bus.perf_clr = 1'b0;
      next();
      at_neg();
      check("clr_then_inc", 32'(bus.stall_count), 32'd1);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         next();
         rst              = ($urandom_range(0, 63) != 0);
         bus.id_valid     = ($urandom_range(0, 7) != 0);
         bus.id_rs        = 5'($urandom_range(0, 7));
         bus.id_rt        = 5'($urandom_range(0, 7));
         bus.id_uses_rt   = 1'($urandom_range(0, 1));
         bus.id_is_branch = 1'($urandom_range(0, 1));
         bus.branch_taken = 1'($urandom_range(0, 1));
         bus.jump         = ($urandom_range(0, 7) == 0);
         bus.ex_dest      = 5'($urandom_range(0, 7));
         bus.ex_wb_en     = 1'($urandom_range(0, 1));
         bus.ex_mem_read  = 1'($urandom_range(0, 1));
         bus.mem_dest     = 5'($urandom_range(0, 7));
         bus.mem_wb_en    = 1'($urandom_range(0, 1));
         bus.mem_mem_read = 1'($urandom_range(0, 1));
         bus.mem_busy     = ($urandom_range(0, 4) == 0);
         bus.perf_clr     = ($urandom_range(0, 15) == 0);
      end
      next();
      rst = 1'b1;
      set_idle();
      at_neg();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
